// File: rtl/run_ctrl.sv
// Run controller for the core: sequences its reset, issues a divided clock-enable,
// counts CE pulses against a budget, honours halt requests and re-resets on watchdog expiry.
module run_ctrl #(
    parameter int unsigned RST_HOLD   = 16,
    parameter int unsigned DIV        = 2,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MAX_CYCLES = 1000,
    parameter int unsigned WDT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             halt,
    input  logic             kick,
    output logic             soc_rst_n,
    output logic             ce,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_HALTED,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] WDT_LAST  = CNT_W'(WDT_CYCLES);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] SAT       = {CNT_W{1'b1}};
    localparam bit               MAX_EN    = (MAX_CYCLES != 0);
    localparam bit               WDT_EN    = (WDT_CYCLES != 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] wdt_q, wdt_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             soc_q, soc_d;
    logic             ce_q, ce_d;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic             to_q, to_d;

    // Next values of the free-running counters, shared by the FSM below
    logic [CNT_W-1:0] hold_inc;
    logic [CNT_W-1:0] div_nxt;
    logic [CNT_W-1:0] wdt_inc;
    logic [CNT_W-1:0] cyc_inc;
    logic             pulse;
    logic             budget_hit;
    logic             wdt_hit;

    always_comb begin
        hold_inc   = hold_q + ONE;
        div_nxt    = (div_q == DIV_LAST) ? '0 : div_q + ONE;
        wdt_inc    = wdt_q + ONE;
        cyc_inc    = (cycles_q == SAT) ? cycles_q : cycles_q + ONE;
        // A CE-high cycle ends at this edge
        pulse      = (state_q == S_RUN) && ce_q;
        budget_hit = MAX_EN && pulse && (cyc_inc == MAX_LAST);
        wdt_hit    = WDT_EN && pulse && !kick && (wdt_inc == WDT_LAST);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_HOLD;
            hold_q   <= '0;
            div_q    <= '0;
            wdt_q    <= '0;
            cycles_q <= '0;
            soc_q    <= 1'b0;
            ce_q     <= 1'b0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            div_q    <= div_d;
            wdt_q    <= wdt_d;
            cycles_q <= cycles_d;
            soc_q    <= soc_d;
            ce_q     <= ce_d;
            run_q    <= run_d;
            done_q   <= done_d;
            to_q     <= to_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        div_d    = div_q;
        wdt_d    = wdt_q;
        cycles_d = cycles_q;
        soc_d    = soc_q;
        ce_d     = 1'b0;
        run_d    = run_q;
        done_d   = done_q;
        to_d     = to_q;

        unique case (state_q)
            S_HOLD: begin
                hold_d = hold_inc;
                soc_d  = 1'b0;
                run_d  = 1'b0;
                if (kick) begin
                    wdt_d = '0;
                end
                if (hold_inc == HOLD_LAST) begin
                    state_d = S_RUN;
                    soc_d   = 1'b1;
                    run_d   = 1'b1;
                    div_d   = '0;
                    ce_d    = (DIV_LAST == '0);
                end
            end

            S_RUN: begin
                div_d = div_nxt;
                if (pulse) begin
                    cycles_d = cyc_inc;
                    wdt_d    = wdt_inc;
                end
                if (kick) begin
                    wdt_d = '0;
                end
                if (budget_hit) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    run_d   = 1'b0;
                end else if (halt) begin
                    state_d = S_HALTED;
                    run_d   = 1'b0;
                end else if (wdt_hit) begin
                    // Re-reset the core; CYCLES keeps counting across it
                    state_d = S_HOLD;
                    to_d    = 1'b1;
                    soc_d   = 1'b0;
                    run_d   = 1'b0;
                    hold_d  = '0;
                    div_d   = '0;
                    wdt_d   = '0;
                end else begin
                    ce_d = (div_nxt == DIV_LAST);
                end
            end

            default: begin
            end
        endcase
    end

    assign soc_rst_n = soc_q;
    assign ce        = ce_q;
    assign running   = run_q;
    assign done      = done_q;
    assign timeout   = to_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: five differently parametrised instances checked every cycle
// against an edge-counting reference model, plus directed literal expectations.
module tb_run_ctrl;

    localparam int N = 5;

    logic        clk;
    logic        rst_n;
    logic        halt    [N];
    logic        kick    [N];
    logic        soc     [N];
    logic        ce      [N];
    logic        running [N];
    logic        done    [N];
    logic        timeout [N];
    logic [31:0] cyc0, cyc1, cyc2, cyc3;
    logic [3:0]  cyc4;

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    run_ctrl #(.RST_HOLD(4), .DIV(1), .CNT_W(32), .MAX_CYCLES(0), .WDT_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .halt(halt[0]), .kick(kick[0]), .soc_rst_n(soc[0]), .ce(ce[0]),
        .running(running[0]), .done(done[0]), .timeout(timeout[0]), .cycles(cyc0));
    run_ctrl #(.RST_HOLD(2), .DIV(3), .CNT_W(32), .MAX_CYCLES(0), .WDT_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .halt(halt[1]), .kick(kick[1]), .soc_rst_n(soc[1]), .ce(ce[1]),
        .running(running[1]), .done(done[1]), .timeout(timeout[1]), .cycles(cyc1));
    run_ctrl #(.RST_HOLD(3), .DIV(1), .CNT_W(32), .MAX_CYCLES(8), .WDT_CYCLES(0)) u2 (
        .clk(clk), .rst_n(rst_n), .halt(halt[2]), .kick(kick[2]), .soc_rst_n(soc[2]), .ce(ce[2]),
        .running(running[2]), .done(done[2]), .timeout(timeout[2]), .cycles(cyc2));
    run_ctrl #(.RST_HOLD(4), .DIV(1), .CNT_W(32), .MAX_CYCLES(0), .WDT_CYCLES(6)) u3 (
        .clk(clk), .rst_n(rst_n), .halt(halt[3]), .kick(kick[3]), .soc_rst_n(soc[3]), .ce(ce[3]),
        .running(running[3]), .done(done[3]), .timeout(timeout[3]), .cycles(cyc3));
    run_ctrl #(.RST_HOLD(3), .DIV(2), .CNT_W(4), .MAX_CYCLES(0), .WDT_CYCLES(5)) u4 (
        .clk(clk), .rst_n(rst_n), .halt(halt[4]), .kick(kick[4]), .soc_rst_n(soc[4]), .ce(ce[4]),
        .running(running[4]), .done(done[4]), .timeout(timeout[4]), .cycles(cyc4));

    function automatic int rh(int i);
        case (i) 0: return 4; 1: return 2; 2: return 3; 3: return 4; default: return 3; endcase
    endfunction
    function automatic int dv(int i);
        case (i) 1: return 3; 4: return 2; default: return 1; endcase
    endfunction
    function automatic int mx(int i);
        return (i == 2) ? 8 : 0;
    endfunction
    function automatic int wd(int i);
        case (i) 3: return 6; 4: return 5; default: return 0; endcase
    endfunction
    function automatic longint sat(int i);
        return (i == 4) ? 64'd15 : 64'd4294967295;
    endfunction
    function automatic longint act_cyc(int i);
        case (i)
            0: return longint'(cyc0);
            1: return longint'(cyc1);
            2: return longint'(cyc2);
            3: return longint'(cyc3);
            default: return longint'(cyc4);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_all(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s u%0d.soc_rst_n", tag, i), 64'(soc[i]), 64'd0);
            chk($sformatf("%s u%0d.ce", tag, i), 64'(ce[i]), 64'd0);
            chk($sformatf("%s u%0d.running", tag, i), 64'(running[i]), 64'd0);
            chk($sformatf("%s u%0d.done", tag, i), 64'(done[i]), 64'd0);
            chk($sformatf("%s u%0d.timeout", tag, i), 64'(timeout[i]), 64'd0);
            chk($sformatf("%s u%0d.cycles", tag, i), 64'(act_cyc(i)), 64'd0);
        end
    endtask

    // Reference model: mode 0 hold, 1 run, 2 halted, 3 done; m_run counts edges since RUN entry
    int     m_mode [N];
    int     m_hold [N];
    int     m_run  [N];
    int     m_wdt  [N];
    longint m_cyc  [N];
    bit     m_to   [N];
    bit     m_pulse;

    function automatic bit exp_ce(int i);
        return (m_mode[i] == 1) && ((m_run[i] % dv(i)) == dv(i) - 1);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                m_mode[i] = 0; m_hold[i] = 0; m_run[i] = 0;
                m_wdt[i]  = 0; m_cyc[i]  = 0; m_to[i]  = 1'b0;
            end else begin
                m_pulse = exp_ce(i);
                if (m_mode[i] == 0) begin
                    m_hold[i]++;
                    if (m_hold[i] == rh(i)) begin
                        m_mode[i] = 1;
                        m_run[i]  = 0;
                    end
                end else if (m_mode[i] == 1) begin
                    m_run[i]++;
                    if (m_pulse) begin
                        if (m_cyc[i] < sat(i)) m_cyc[i]++;
                        m_wdt[i]++;
                    end
                    if (kick[i]) m_wdt[i] = 0;
                    if (mx(i) != 0 && m_pulse && m_cyc[i] == longint'(mx(i))) begin
                        m_mode[i] = 3;
                    end else if (halt[i]) begin
                        m_mode[i] = 2;
                    end else if (wd(i) != 0 && m_pulse && !kick[i] && m_wdt[i] == wd(i)) begin
                        m_to[i]   = 1'b1;
                        m_mode[i] = 0;
                        m_hold[i] = 0;
                        m_wdt[i]  = 0;
                    end
                end
            end
        end
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("u%0d.soc_rst_n", i), 64'(soc[i]), 64'(m_mode[i] != 0));
            chk($sformatf("u%0d.ce", i), 64'(ce[i]), 64'(exp_ce(i)));
            chk($sformatf("u%0d.running", i), 64'(running[i]), 64'(m_mode[i] == 1));
            chk($sformatf("u%0d.done", i), 64'(done[i]), 64'(m_mode[i] == 3));
            chk($sformatf("u%0d.timeout", i), 64'(timeout[i]), 64'(m_to[i]));
            chk($sformatf("u%0d.cycles", i), 64'(act_cyc(i)), 64'(m_cyc[i]));
        end
    end

    int len;
    int kdiv;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            halt[i] = 1'b0;
            kick[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk_reset_all("por");
        rst_n = 1'b1;

        // Directed run: the following edge is E1
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #2;
            case (e)
                3:  chk("E3 u0.soc_rst_n", 64'(soc[0]), 64'd0);
                4: begin
                    chk("E4 u0.soc_rst_n", 64'(soc[0]), 64'd1);
                    chk("E4 u0.ce", 64'(ce[0]), 64'd1);
                    chk("E4 u1.ce", 64'(ce[1]), 64'd1);
                end
                5:  chk("E5 u1.ce", 64'(ce[1]), 64'd0);
                7:  chk("E7 u1.ce", 64'(ce[1]), 64'd1);
                10: begin
                    chk("E10 u3.timeout", 64'(timeout[3]), 64'd1);
                    chk("E10 u3.soc_rst_n", 64'(soc[3]), 64'd0);
                    chk("E10 u3.cycles", 64'(cyc3), 64'd6);
                end
                11: begin
                    chk("E11 u2.done", 64'(done[2]), 64'd1);
                    chk("E11 u2.cycles", 64'(cyc2), 64'd8);
                    chk("E11 u2.ce", 64'(ce[2]), 64'd0);
                end
                13: chk("E13 u3.soc_rst_n", 64'(soc[3]), 64'd0);
                14: begin
                    chk("E14 u0.cycles", 64'(cyc0), 64'd10);
                    chk("E14 u3.soc_rst_n", 64'(soc[3]), 64'd1);
                    chk("E14 u3.running", 64'(running[3]), 64'd1);
                end
                17: chk("E17 u1.cycles", 64'(cyc1), 64'd5);
                21: begin
                    chk("E21 u0.running", 64'(running[0]), 64'd0);
                    chk("E21 u0.ce", 64'(ce[0]), 64'd0);
                    chk("E21 u0.cycles", 64'(cyc0), 64'd16);
                    chk("E21 u0.soc_rst_n", 64'(soc[0]), 64'd1);
                    chk("E21 u3.soc_rst_n", 64'(soc[3]), 64'd1);
                    chk("E21 u3.cycles", 64'(cyc3), 64'd13);
                end
                31: begin
                    chk("E31 u2.cycles", 64'(cyc2), 64'd8);
                    chk("E31 u2.soc_rst_n", 64'(soc[2]), 64'd1);
                end
                35: chk("E35 u0.cycles", 64'(cyc0), 64'd16);
                default: ;
            endcase
            @(negedge clk);
            halt[0] = (e + 1 == 20);
            kick[3] = (e + 1 == 20);
            kick[0] = (e + 1 == 30);
        end

        // Asynchronous reset between edges must clear everything at once
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        chk_reset_all("async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Randomised epochs, each ended by a mid-cycle asynchronous reset
        for (int ep = 0; ep < 6; ep++) begin
            len  = (ep == 0) ? 110 : int'($urandom_range(60, 260));
            kdiv = int'($urandom_range(2, 9));
            for (int c = 0; c < len; c++) begin
                for (int i = 0; i < N; i++) begin
                    if (ep == 0 && i == 3) begin
                        halt[i] = 1'b0;
                        kick[i] = (c % 5 == 0);
                    end else begin
                        halt[i] = ($urandom_range(0, 120) == 0);
                        kick[i] = ($urandom_range(0, kdiv - 1) == 0);
                    end
                end
                @(negedge clk);
            end
            if (ep == 0) begin
                chk("kicked u3.timeout", 64'(timeout[3]), 64'd0);
                chk("kicked u3.running", 64'(running[3]), 64'd1);
            end
            for (int i = 0; i < N; i++) begin
                halt[i] = 1'b0;
                kick[i] = 1'b0;
            end
            @(posedge clk);
            #($urandom_range(3, 8));
            rst_n = 1'b0;
            #1;
            chk_reset_all($sformatf("ep%0d", ep));
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
